// File: rtl/ifc_pkg.sv
// Shared types for the round-robin datapath arbiter: FSM states, default widths
// and the operand bundle.
package ifc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } ifc_state_e;

  localparam int AW_D = 8;
  localparam int XW_D = 16;

  typedef struct packed {
    logic [AW_D-1:0] a;
    logic [AW_D-1:0] b;
    logic [XW_D-1:0] x;
    logic [XW_D-1:0] y;
  } ifc_op_t;

endpackage

// File: rtl/ifc_rr_pick.sv
// Combinational round-robin picker: the first set REQ bit searching upward
// from LAST+1, wrapping modulo NREQ.
module ifc_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] REQ,
  input  logic [IDW-1:0]  LAST,
  output logic [NREQ-1:0] GNT,
  output logic [IDW-1:0]  IDX,
  output logic            ANY
);

  always_comb begin
    int j;
    GNT = '0;
    IDX = '0;
    ANY = 1'b0;
    j   = 0;
    // Offset NREQ lands back on LAST itself, so it has lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(LAST) + k) % NREQ;
      if (!ANY && REQ[j]) begin
        ANY    = 1'b1;
        IDX    = IDW'(j);
        GNT[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifc_arbiter.sv
// Shares one external datapath among NREQ requesters: round-robin grant,
// registered operands, DP_LAT-cycle wait, then a valid/ready response.
module ifc_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = ifc_pkg::AW_D,
  parameter int XW     = ifc_pkg::XW_D,
  parameter int DP_LAT = 1,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ_VALID,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [NREQ*AW-1:0] REQ_A,
  input  logic [NREQ*AW-1:0] REQ_B,
  input  logic [NREQ*XW-1:0] REQ_X,
  input  logic [NREQ*XW-1:0] REQ_Y,
  output logic [AW-1:0]     DP_A,
  output logic [AW-1:0]     DP_B,
  output logic [XW-1:0]     DP_X,
  output logic [XW-1:0]     DP_Y,
  input  logic [XW-1:0]     DP_Z,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IDW-1:0]    RSP_ID,
  output logic [XW-1:0]     RSP_Z,
  output logic              BUSY,
  output logic [15:0]       OPS_DONE
);
  import ifc_pkg::*;

  ifc_state_e     state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic [XW-1:0]  dp_x_q, dp_x_d, dp_y_q, dp_y_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [XW-1:0]  rsp_z_q, rsp_z_d;
  logic [15:0]    ops_done_q, ops_done_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  ifc_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .REQ  (REQ_VALID),
    .LAST (last_q),
    .GNT  (pick_gnt),
    .IDX  (pick_idx),
    .ANY  (pick_any)
  );

  always_comb begin
    REQ_READY   = '0;
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_x_d      = dp_x_q;
    dp_y_d      = dp_y_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    ops_done_d  = ops_done_q;
    unique case (state_q)
      ifc_pkg::IDLE: begin
        if (pick_any) begin
          REQ_READY = RST ? '0 : pick_gnt;
          dp_a_d    = REQ_A[pick_idx*AW +: AW];
          dp_b_d    = REQ_B[pick_idx*AW +: AW];
          dp_x_d    = REQ_X[pick_idx*XW +: XW];
          dp_y_d    = REQ_Y[pick_idx*XW +: XW];
          id_d      = pick_idx;
          last_d    = pick_idx;
          cnt_d     = 4'(DP_LAT - 1);
          state_d   = ifc_pkg::BUSY;
        end
      end
      ifc_pkg::BUSY: begin
        if (cnt_q == 4'd0) begin
          rsp_z_d     = DP_Z;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ifc_pkg::RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ifc_pkg::RESP: begin
        // No grant here; arbitration resumes the cycle after the handshake.
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
          state_d     = ifc_pkg::IDLE;
        end
      end
      default: state_d = ifc_pkg::IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ifc_pkg::IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_x_q      <= '0;
      dp_y_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_x_q      <= dp_x_d;
      dp_y_q      <= dp_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign DP_A      = dp_a_q;
  assign DP_B      = dp_b_q;
  assign DP_X      = dp_x_q;
  assign DP_Y      = dp_y_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_Z     = rsp_z_q;
  assign BUSY      = (state_q != ifc_pkg::IDLE);
  assign OPS_DONE  = ops_done_q;

endmodule
